// File: rtl/key_stepper.sv
// key_stepper: two debounced push-buttons step a 3-bit position up/down,
// shown on an 8-bit one-hot LED bar.
//
// Ports
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset
//   KEY  : raw active-low push-buttons (async to clk); [0] = up, [1] = down
//   pos  : registered position 0..7
//   LED  : one-hot display, LED[7-pos] lit
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized samples to accept a press/release (>= 2)
//   REPEAT_CYCLES   : HELD cycles between auto-repeat steps (>= 1)
//
// Configuration
//   KEY_AUTOREPEAT_EN : when defined, a held key emits an extra step every
//                       REPEAT_CYCLES cycles; when undefined no repeat logic exists.

module key_stepper #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] KEY,
    output logic [2:0] pos,
    output logic [7:0] LED
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } key_state_t;

    // Elaboration-time guard on parameter ranges.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("key_stepper: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
    end

    logic [1:0] key_meta;
    logic [1:0] key_sync;
    logic [1:0] step;   // registered one-cycle pulses: [0] up, [1] down

    // Synchronizer flops reset to 1 so a key held through reset looks
    // released and is debounced as a fresh press afterwards.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true 2-flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_state_t       state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             step_q, step_nxt;
        logic             pressed;

        assign pressed = ~key_sync[k];
        assign step[k] = step_q;

`ifdef KEY_AUTOREPEAT_EN
        localparam int                RCNT_W    = $clog2(REPEAT_CYCLES) + 1;
        localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);
        logic [RCNT_W-1:0] rcnt, rcnt_nxt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) rcnt <= '0;
            else     rcnt <= rcnt_nxt;
        end
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                cnt    <= '0;
                step_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                step_q <= step_nxt;
            end
        end

        // NOTE: every output of this block gets a default before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            step_nxt  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_nxt  = rcnt;
`endif
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state_nxt = PRESS_CHK;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!pressed) begin
                        state_nxt = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        step_nxt  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        rcnt_nxt  = '0;
`endif
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state_nxt = RELEASE_CHK;
                        cnt_nxt   = '0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (rcnt == RCNT_LAST) begin
                        step_nxt = 1'b1;
                        rcnt_nxt = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
`endif
                end
                RELEASE_CHK: begin
                    if (pressed) begin
                        // Bounce during release: back to HELD, no new step.
                        state_nxt = HELD;
`ifdef KEY_AUTOREPEAT_EN
                        rcnt_nxt  = '0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Simultaneous up and down pulses cancel; 3-bit arithmetic wraps mod 8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= 3'd0;
        end else if (step[0] && !step[1]) begin
            pos <= pos + 3'd1;
        end else if (step[1] && !step[0]) begin
            pos <= pos - 3'd1;
        end
    end

    assign LED = 8'h80 >> pos;

endmodule

// File: doc/key_stepper.md
KEY_STEPPER -- requirements
Module: key_stepper

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable synchronized samples needed to accept a press or release; legal range >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 12500000, HELD-state cycles between auto-repeat steps; used only when KEY_AUTOREPEAT_EN is defined; legal range >= 1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 KEY  input  2  raw push-buttons, active-low, asynchronous to clk; KEY[0] steps up, KEY[1] steps down.
REQ-006 pos  output  3  current position, registered.
REQ-007 LED  output  8  one-hot position display.

Function
REQ-008 Each KEY bit SHALL pass through its own 2-flop synchronizer; all downstream logic SHALL use only the synchronizer output, treated as "pressed" when low.
REQ-009 Each key SHALL have an independent FSM with states IDLE, PRESS_CHK, HELD and RELEASE_CHK, plus a debounce counter of width $clog2(DEBOUNCE_CYCLES)+1.
REQ-010 IDLE: pressed -> PRESS_CHK with counter cleared to 0; otherwise remain in IDLE.
REQ-011 PRESS_CHK: released -> IDLE with no pulse; pressed with counter == DEBOUNCE_CYCLES-1 -> HELD and a one-cycle step pulse; otherwise counter increments.
REQ-012 HELD: released -> RELEASE_CHK with counter cleared; otherwise remain in HELD.
REQ-013 RELEASE_CHK: pressed -> HELD with no pulse; released with counter == DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-014 A step pulse SHALL be registered; pos SHALL update on the clock edge after the edge that asserts the pulse.
REQ-015 An up pulse alone SHALL set pos to (pos+1) mod 8, so 7 wraps to 0.
REQ-016 A down pulse alone SHALL set pos to (pos-1) mod 8, so 0 wraps to 7.
REQ-017 Up and down pulses in the same cycle SHALL cancel; pos is unchanged.
REQ-018 LED SHALL be combinational from pos: LED[7-pos] = 1 and all other bits 0, so pos 0 lights LED[7] and pos 7 lights LED[0].
REQ-019 Each accepted press SHALL produce exactly one step, except auto-repeat (REQ-024); glitches shorter than DEBOUNCE_CYCLES SHALL produce no step.

Reset
REQ-020 While rst = 1, all synchronizer flops SHALL hold "released" (1), both FSMs SHALL be in IDLE, and all counters and pulses SHALL be 0.
REQ-021 While rst = 1, pos SHALL be 0 and LED SHALL be 8'h80.
REQ-022 Assertion of rst mid-debounce or mid-HELD SHALL abort without any step.
REQ-023 After rst deasserts with a key already held, that key SHALL be debounced as a fresh press.

Configuration
REQ-024 With KEY_AUTOREPEAT_EN defined, each FSM SHALL run a repeat counter in HELD, cleared on HELD entry; after REPEAT_CYCLES consecutive HELD cycles it SHALL emit one step pulse and clear the counter.
REQ-025 Moving from RELEASE_CHK back to HELD SHALL clear the repeat counter.
REQ-026 Without KEY_AUTOREPEAT_EN, no repeat logic SHALL exist, REQ-024 and REQ-025 do not apply, and REQ-002 is ignored.

Verification (bench: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-027 Reset scenario: assert rst -> pos=0, LED=8'h80; then hold KEY=2'b11 for 100 cycles -> pos stays 0.
REQ-028 Clean press scenario: hold KEY[0] low for 20 cycles, then release -> exactly one step, pos=1, LED=8'h40.
REQ-029 Bounce and glitch scenario: pulse KEY[0] low for 3 cycles, high for 1, low for 3, then high -> pos unchanged; KEY[1] debounced press from pos=0 -> pos=7, LED=8'h01.
REQ-030 Wrap scenario: eight debounced KEY[0] presses starting at pos=0 -> pos=0 again.
REQ-031 Simultaneous press scenario: KEY=2'b00 asserted on the same cycle and held -> both pulses land together and pos is unchanged; with KEY_AUTOREPEAT_EN, hold KEY[0] alone for 40 cycles after acceptance -> 1+4 steps.
REQ-032 Reset abort scenario: assert rst 2 cycles into PRESS_CHK with KEY[0] held, release rst while still held -> pos=0 during reset, then exactly one step after DEBOUNCE_CYCLES.
